one_wire_slave_phy: RTL and testbench
=====================================

// Module: one_wire_slave_phy
// PURPOSE
//  1-Wire responder (slave) physical layer; counterpart to the PeriPlex 1-Wire master PHY.
//  Detects master reset pulses and answers with a presence pulse.
//  Receives bytes from master write slots into an RX FIFO and answers master read slots from a TX FIFO.
//  Sits between the open-drain pad (data_in/data_out/data_oe) and byte FIFOs in the slave-emulation path.
// PARAMETERS
//  CLK_FREQ_MHZ  50   clk frequency in MHz; all timing localparams = us * CLK_FREQ_MHZ cycles
//  T_RSTL_US     400  minimum continuous bus-low (not self-driven) treated as master reset
//  T_PDH_US      30   delay from reset-pulse rising edge to presence pulse start
//  T_PDL_US      120  presence pulse low duration
//  T_SAMPLE_US   30   delay from slot falling edge to write-slot sample point
//  T_HOLD0_US    30   bus hold-low duration when transmitting a 0 in a read slot
//  CNT_W         20   width of cycle counter; must hold T_RSTL_US*CLK_FREQ_MHZ
// PORTS
//  clk            in   1  system clock
//  rst_n          in   1  asynchronous active-low reset
//  data_in        in   1  1-Wire bus level (async; 2-FF synchronised internally)
//  data_out       out  1  pad output value; constant 0
//  data_oe        out  1  1 = pull bus low
//  tx_fifo_empty  in   1  TX FIFO empty
//  tx_fifo_en     out  1  TX FIFO pop, one-cycle pulse (FWFT: data valid while !empty)
//  tx_fifo_data   in   8  byte to send on next 8 read slots, LSB first
//  rx_fifo_full   in   1  RX FIFO full
//  rx_fifo_en     out  1  RX FIFO push, one-cycle pulse
//  rx_fifo_data   out  8  received byte, valid with rx_fifo_en
//  bus_reset      out  1  one-cycle pulse on master reset detect
//  busy           out  1  1 while presence pulse or a byte (partial bits) is in progress
//  rx_overrun     out  1  sticky: byte dropped because rx_fifo_full; cleared on bus_reset
// BEHAVIOUR
//  - Reset: all outputs 0; FSM IDLE; bit_cnt 0; tx_mode 0; counters 0.
//  - Bus sampled via 2-FF sync (2 cycles latency); falling edge = sync high->low while data_oe=0.
//  - States: IDLE, SLOT_LOW, WAIT_HIGH, PRES_WAIT, PRES_DRIVE.
//  - IDLE, bus high, bit_cnt=0, !tx_fifo_empty: pulse tx_fifo_en, latch byte, tx_mode=1.
//    Falling edge in the same cycle wins: slot handled as write slot, no pop.
//  - IDLE + falling edge -> SLOT_LOW, counter cleared.
//    tx_mode=1 and current bit 0: data_oe=1 for T_HOLD0 cycles then release.
//    tx_mode=0: sample bus at T_SAMPLE cycles, shift in LSB first.
//    Then -> WAIT_HIGH; bus high -> IDLE, bit_cnt++.
//  - bit_cnt 7->0 wrap: rx byte -> rx_fifo_en pulse next cycle if !rx_fifo_full, else rx_overrun=1.
//    Tx byte completes: tx_mode=0.
//  - Reset detect, any state except PRES_*: bus low with data_oe=0 for T_RSTL cycles -> bus_reset pulse.
//    Discard partial rx/tx byte (popped tx byte lost), bit_cnt=0, tx_mode=0, rx_overrun=0.
//    Wait for bus high -> PRES_WAIT.
//  - PRES_WAIT T_PDH cycles -> PRES_DRIVE (data_oe=1) T_PDL cycles -> release -> IDLE.
//    A new falling edge during PRES_WAIT restarts reset timing.
//  - Bus held low beyond T_RSTL: single bus_reset pulse only; presence follows the rising edge.
//  - Counter saturates at all-ones; never wraps.
//  - busy = (state!=IDLE) | (bit_cnt!=0) | tx_mode.
// STRUCTURE
//  - Shared package ow_pkg: state encoding, us->cycle conversion function, default timing constants (also used by master PHY).
//  - Single sub-module ow_sync_edge: 2-FF synchroniser plus falling/rising edge detect.
//  - Main FSM, counter, shift registers inline.
// TESTING (CLK_FREQ_MHZ=50)
//  - Master low 480us then release -> bus_reset pulse; data_oe low 30us after release (+-2 cyc), high 120us (6000 cyc).
//  - Master writes 0xA5 (8 write slots, 60us each) -> exactly one rx_fifo_en, rx_fifo_data=0xA5.
//  - tx_fifo_data=0x3C, 8 master read slots -> data_oe asserted 30us in slots 0,1,6,7 only; one tx_fifo_en.
//  - Reset pulse after 3 bits of 0xFF write -> no rx push, bus_reset=1, presence issued; next byte 0x12 received intact.
//  - rx_fifo_full=1 during byte 0x55 -> no rx_fifo_en, rx_overrun=1; next reset -> rx_overrun=0.
//  - rst_n asserted mid-presence (data_oe=1) -> data_oe=0 immediately; IDLE; busy=0.

Source files
------------

// File: rtl/ow_pkg.sv
// Shared 1-Wire definitions: slave FSM encoding, default bus timing and
// microsecond-to-cycle conversion used by both master and slave PHYs.
package ow_pkg;

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_SLOT_LOW   = 3'd1,
    S_WAIT_HIGH  = 3'd2,
    S_PRES_WAIT  = 3'd3,
    S_PRES_DRIVE = 3'd4
  } ow_state_e;

  localparam int unsigned OW_CLK_FREQ_MHZ = 50;
  localparam int unsigned OW_T_RSTL_US    = 400;
  localparam int unsigned OW_T_PDH_US     = 30;
  localparam int unsigned OW_T_PDL_US     = 120;
  localparam int unsigned OW_T_SAMPLE_US  = 30;
  localparam int unsigned OW_T_HOLD0_US   = 30;
  localparam int unsigned OW_SYNC_LAT     = 2;

  function automatic int unsigned us_to_cyc(input int unsigned us, input int unsigned mhz);
    return us * mhz;
  endfunction

endpackage

// File: rtl/ow_sync_edge.sv
// Two-flop synchroniser for the asynchronous 1-Wire pad level, with
// falling/rising edge detection on the synchronised level.
module ow_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_level,
  output logic o_fall,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_level = r_sync;
  assign o_fall  = r_prev & ~r_sync;
  assign o_rise  = ~r_prev & r_sync;

endmodule

// File: rtl/one_wire_slave_phy.sv
// 1-Wire responder PHY: reset detect + presence pulse, write-slot capture into
// the RX FIFO and read-slot answers from the TX FIFO.
module one_wire_slave_phy
  import ow_pkg::*;
#(
  parameter int unsigned CLK_FREQ_MHZ = OW_CLK_FREQ_MHZ,
  parameter int unsigned T_RSTL_US    = OW_T_RSTL_US,
  parameter int unsigned T_PDH_US     = OW_T_PDH_US,
  parameter int unsigned T_PDL_US     = OW_T_PDL_US,
  parameter int unsigned T_SAMPLE_US  = OW_T_SAMPLE_US,
  parameter int unsigned T_HOLD0_US   = OW_T_HOLD0_US,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       data_in,
  output logic       data_out,
  output logic       data_oe,
  input  logic       tx_fifo_empty,
  output logic       tx_fifo_en,
  input  logic [7:0] tx_fifo_data,
  input  logic       rx_fifo_full,
  output logic       rx_fifo_en,
  output logic [7:0] rx_fifo_data,
  output logic       bus_reset,
  output logic       busy,
  output logic       rx_overrun
);

  localparam logic [CNT_W-1:0] RSTL_LAST   = CNT_W'(us_to_cyc(T_RSTL_US, CLK_FREQ_MHZ) - 1);
  // Presence delay is measured from the pad edge, so absorb the synchroniser latency.
  localparam logic [CNT_W-1:0] PDH_LAST    = CNT_W'(us_to_cyc(T_PDH_US, CLK_FREQ_MHZ) - OW_SYNC_LAT - 1);
  localparam logic [CNT_W-1:0] PDL_LAST    = CNT_W'(us_to_cyc(T_PDL_US, CLK_FREQ_MHZ) - 1);
  localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(us_to_cyc(T_SAMPLE_US, CLK_FREQ_MHZ) - 1);
  localparam logic [CNT_W-1:0] HOLD0_LAST  = CNT_W'(us_to_cyc(T_HOLD0_US, CLK_FREQ_MHZ) - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  ow_state_e        r_state;
  ow_state_e        w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_low_cnt;
  logic [2:0]       r_bit_cnt;
  logic             r_tx_mode;
  logic [7:0]       r_tx_byte;
  logic [7:0]       r_rx_shift;
  logic             r_rx_en;
  logic             r_rx_overrun;
  logic             r_rst_pend;

  logic w_level;
  logic w_fall_raw;
  logic w_rise;
  logic w_fall;
  logic w_oe;
  logic w_pop;
  logic w_low_run;
  logic w_rst_det;
  logic w_slot_last;
  logic w_bit_done;

  ow_sync_edge u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (data_in),
    .o_level (w_level),
    .o_fall  (w_fall_raw),
    .o_rise  (w_rise)
  );

  // Our own drive must never look like a master slot start or reset pulse.
  assign w_fall      = w_fall_raw & ~w_oe;
  assign w_low_run   = ~w_level & ~w_oe;
  assign w_rst_det   = w_low_run && (r_low_cnt == RSTL_LAST) &&
                       (r_state != S_PRES_WAIT) && (r_state != S_PRES_DRIVE);
  assign w_slot_last = (r_cnt == (r_tx_mode ? HOLD0_LAST : SAMPLE_LAST));
  assign w_bit_done  = (r_state == S_WAIT_HIGH) && !r_rst_pend && w_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_rst_det) begin
      w_next = S_WAIT_HIGH;
    end else begin
      case (r_state)
        S_IDLE:       if (w_fall) w_next = S_SLOT_LOW;
        S_SLOT_LOW:   if (w_slot_last) w_next = S_WAIT_HIGH;
        S_WAIT_HIGH: begin
          if (r_rst_pend) begin
            if (w_rise) w_next = S_PRES_WAIT;
          end else if (w_level) begin
            w_next = S_IDLE;
          end
        end
        S_PRES_WAIT: begin
          if (w_fall)                     w_next = S_IDLE;
          else if (r_cnt == PDH_LAST)     w_next = S_PRES_DRIVE;
        end
        S_PRES_DRIVE: if (r_cnt == PDL_LAST) w_next = S_IDLE;
        default:      w_next = S_IDLE;
      endcase
    end
  end

  always_comb begin
    w_oe  = (r_state == S_PRES_DRIVE) ||
            ((r_state == S_SLOT_LOW) && r_tx_mode && !r_tx_byte[r_bit_cnt]);
    w_pop = (r_state == S_IDLE) && w_level && !w_fall && (r_bit_cnt == 3'd0) &&
            !r_tx_mode && !tx_fifo_empty;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt        <= '0;
      r_low_cnt    <= '0;
      r_bit_cnt    <= 3'd0;
      r_tx_mode    <= 1'b0;
      r_tx_byte    <= 8'h00;
      r_rx_shift   <= 8'h00;
      r_rx_en      <= 1'b0;
      r_rx_overrun <= 1'b0;
      r_rst_pend   <= 1'b0;
    end else begin
      r_cnt     <= (w_next != r_state) ? '0 : sat_inc(r_cnt);
      r_low_cnt <= w_low_run ? sat_inc(r_low_cnt) : '0;
      r_rx_en   <= w_bit_done && (r_bit_cnt == 3'd7) && !r_tx_mode && !rx_fifo_full;
      if (w_rst_det) begin
        r_bit_cnt    <= 3'd0;
        r_tx_mode    <= 1'b0;
        r_rx_overrun <= 1'b0;
        r_rst_pend   <= 1'b1;
      end else begin
        if (w_pop) begin
          r_tx_byte <= tx_fifo_data;
          r_tx_mode <= 1'b1;
        end
        if ((r_state == S_SLOT_LOW) && w_slot_last && !r_tx_mode)
          r_rx_shift <= {w_level, r_rx_shift[7:1]};
        if ((r_state == S_WAIT_HIGH) && r_rst_pend && w_rise)
          r_rst_pend <= 1'b0;
        if (w_bit_done) begin
          r_bit_cnt <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) begin
            if (r_tx_mode)         r_tx_mode    <= 1'b0;
            else if (rx_fifo_full) r_rx_overrun <= 1'b1;
          end
        end
      end
    end
  end

  assign data_out     = 1'b0;
  assign data_oe      = w_oe;
  assign tx_fifo_en   = w_pop;
  assign rx_fifo_en   = r_rx_en;
  assign rx_fifo_data = r_rx_shift;
  assign bus_reset    = w_rst_det;
  assign busy         = (r_state != S_IDLE) || (r_bit_cnt != 3'd0) || r_tx_mode;
  assign rx_overrun   = r_rx_overrun;

endmodule

// File: tb/tb_one_wire_slave_phy.sv
// Directed bench for one_wire_slave_phy: a wired-AND bus model with a
// master driven from tasks, vector table for byte transfers, hand-written reset cases.
`timescale 1ns/1ps
module tb_one_wire_slave_phy;

  localparam int MHZ   = 10;
  localparam int PDH   = 30 * MHZ;
  localparam int PDL   = 120 * MHZ;
  localparam int HOLD0 = 30 * MHZ;
  localparam int RSTLO = 480 * MHZ;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       m_low = 1'b0;
  logic       tx_fifo_empty = 1'b1;
  logic       rx_fifo_full = 1'b0;
  logic [7:0] tx_fifo_data = 8'h00;
  wire        data_in, data_out, data_oe, tx_fifo_en, rx_fifo_en;
  wire        bus_reset, busy, rx_overrun;
  wire  [7:0] rx_fifo_data;

  assign data_in = ~(m_low | data_oe);
  always #50 clk = ~clk;

  one_wire_slave_phy #(.CLK_FREQ_MHZ(MHZ)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .data_in       (data_in),
    .data_out      (data_out),
    .data_oe       (data_oe),
    .tx_fifo_empty (tx_fifo_empty),
    .tx_fifo_en    (tx_fifo_en),
    .tx_fifo_data  (tx_fifo_data),
    .rx_fifo_full  (rx_fifo_full),
    .rx_fifo_en    (rx_fifo_en),
    .rx_fifo_data  (rx_fifo_data),
    .bus_reset     (bus_reset),
    .busy          (busy),
    .rx_overrun    (rx_overrun)
  );

  typedef struct {
    bit         rd;
    logic [7:0] data;
    bit         full;
    int         exp_push;
    logic [7:0] exp_rx;
    bit         exp_ovr;
    int         exp_pop;
  } vec_t;

  vec_t       vecs[7];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         rx_pushes = 0;
  int         tx_pops = 0;
  int         resets = 0;
  logic [7:0] last_rx = 8'h00;

  always @(negedge clk) begin
    if (rx_fifo_en) begin
      rx_pushes <= rx_pushes + 1;
      last_rx   <= rx_fifo_data;
    end
    if (tx_fifo_en) tx_pops <= tx_pops + 1;
    if (bus_reset)  resets  <= resets + 1;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_cmp++;
    if (act < lo || act > hi) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_bit(input logic b);
    m_low = 1'b1;
    wait_cyc(b ? 60 : 600);
    m_low = 1'b0;
    wait_cyc(b ? 590 : 50);
  endtask

  task automatic write_byte(input logic [7:0] d);
    for (int i = 0; i < 8; i++) write_bit(d[i]);
  endtask

  task automatic read_byte(input logic [7:0] d, input string tag);
    for (int s = 0; s < 8; s++) begin
      int c;
      c = 0;
      m_low = 1'b1;
      for (int i = 0; i < 650; i++) begin
        @(negedge clk);
        if (i == 19) m_low = 1'b0;
        if (data_oe) c++;
      end
      chk($sformatf("%s slot%0d oe_cycles", tag, s), c, d[s] ? 0 : HOLD0);
    end
  endtask

  task automatic pres_chk(input string tag);
    int d;
    int h;
    d = 0;
    while (!data_oe && d < 1000) begin
      @(negedge clk);
      d++;
    end
    chk_range({tag, " presence_delay"}, d, PDH - 2, PDH + 2);
    h = 0;
    while (data_oe && h < 3000) begin
      @(negedge clk);
      h++;
    end
    chk({tag, " presence_len"}, h, PDL);
  endtask

  initial begin
    #(100 * 90000);
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int p0, t0, r0;
    vecs[0] = '{1'b0, 8'h12, 1'b0, 1, 8'h12, 1'b0, 0};
    vecs[1] = '{1'b0, 8'hA5, 1'b0, 1, 8'hA5, 1'b0, 0};
    vecs[2] = '{1'b1, 8'h3C, 1'b0, 0, 8'h00, 1'b0, 1};
    vecs[3] = '{1'b0, 8'hFF, 1'b0, 1, 8'hFF, 1'b0, 0};
    vecs[4] = '{1'b1, 8'h81, 1'b0, 0, 8'h00, 1'b0, 1};
    vecs[5] = '{1'b0, 8'h00, 1'b0, 1, 8'h00, 1'b0, 0};
    vecs[6] = '{1'b0, 8'h55, 1'b1, 0, 8'h00, 1'b1, 0};

    wait_cyc(3);
    chk("rst data_oe", data_oe, 0);
    chk("rst data_out", data_out, 0);
    chk("rst tx_fifo_en", tx_fifo_en, 0);
    chk("rst rx_fifo_en", rx_fifo_en, 0);
    chk("rst rx_fifo_data", rx_fifo_data, 0);
    chk("rst bus_reset", bus_reset, 0);
    chk("rst busy", busy, 0);
    chk("rst rx_overrun", rx_overrun, 0);
    rst_n = 1'b1;
    wait_cyc(10);
    chk("idle busy", busy, 0);

    // Master reset held past the detect threshold: one pulse, presence after release.
    r0 = resets;
    m_low = 1'b1;
    wait_cyc(RSTLO);
    m_low = 1'b0;
    chk("por bus_reset pulses", resets - r0, 1);
    pres_chk("por");
    wait_cyc(20);
    chk("por busy after", busy, 0);

    // Reset in the middle of a byte discards the partial bits.
    p0 = rx_pushes;
    for (int i = 0; i < 3; i++) write_bit(1'b1);
    chk("mid busy partial", busy, 1);
    r0 = resets;
    m_low = 1'b1;
    wait_cyc(RSTLO);
    m_low = 1'b0;
    chk("mid bus_reset pulses", resets - r0, 1);
    pres_chk("mid");
    wait_cyc(20);
    chk("mid rx pushes", rx_pushes - p0, 0);
    chk("mid busy after", busy, 0);

    for (int v = 0; v < 7; v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      p0 = rx_pushes;
      t0 = tx_pops;
      r0 = resets;
      if (vecs[v].rd) begin
        @(posedge clk);
        #1;
        tx_fifo_data  = vecs[v].data;
        tx_fifo_empty = 1'b0;
        @(posedge clk);
        #1;
        tx_fifo_empty = 1'b1;
        @(negedge clk);
        read_byte(vecs[v].data, tag);
      end else begin
        rx_fifo_full = vecs[v].full;
        write_byte(vecs[v].data);
      end
      wait_cyc(10);
      rx_fifo_full = 1'b0;
      chk({tag, " rx pushes"}, rx_pushes - p0, vecs[v].exp_push);
      if (vecs[v].exp_push != 0) chk({tag, " rx data"}, last_rx, vecs[v].exp_rx);
      chk({tag, " rx_overrun"}, rx_overrun, vecs[v].exp_ovr);
      chk({tag, " tx pops"}, tx_pops - t0, vecs[v].exp_pop);
      chk({tag, " bus_reset pulses"}, resets - r0, 0);
      chk({tag, " busy after"}, busy, 0);
    end

    // Reset clears the sticky overrun; then a hard reset mid-presence.
    r0 = resets;
    m_low = 1'b1;
    wait_cyc(RSTLO);
    m_low = 1'b0;
    chk("fin bus_reset pulses", resets - r0, 1);
    for (int i = 0; i < 1000 && !data_oe; i++) @(negedge clk);
    chk("fin presence started", data_oe, 1);
    chk("fin rx_overrun cleared", rx_overrun, 0);
    wait_cyc(100);
    rst_n = 1'b0;
    #1;
    chk("fin rst data_oe", data_oe, 0);
    chk("fin rst busy", busy, 0);
    wait_cyc(2);
    rst_n = 1'b1;
    wait_cyc(10);
    chk("fin idle data_oe", data_oe, 0);
    chk("fin idle busy", busy, 0);
    chk("fin idle bus_reset", bus_reset, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
